// File: rtl/scope_capture_ctrl.sv
// Trigger/capture sequencer for the scope ping-pong buffers: finds a level crossing,
// writes NSAMP (optionally decimated) samples to the back buffer, swaps on frame_start.
module scope_capture_ctrl #(
  parameter int NSAMP   = 640,
  parameter int AW      = 10,
  parameter int DW      = 9,
  parameter int TIMEOUT = 4096
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] sample,
  input  logic          valid,
  input  logic [DW-1:0] trig_level,
  input  logic          rising,
  input  logic          auto_en,
  input  logic [7:0]    decim,
  input  logic          frame_start,
  output logic [AW-1:0] wr_addr,
  output logic [15:0]   wr_data,
  output logic          wr_en,
  output logic          front_sel,
  output logic          full,
  output logic          triggered
);

  localparam int            TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
  localparam logic [AW-1:0] LAST = AW'(NSAMP - 1);

  typedef enum logic [1:0] {WAIT_TRIG, CAPTURE, SWAP_WAIT} state_t;

  state_t        state, state_nx;
  logic [TW-1:0] tcnt, tcnt_nx;
  logic [7:0]    dcnt, dcnt_nx;
  logic [7:0]    decim_lat, decim_lat_nx;
  logic          prev_vld, prev_vld_nx;
  logic [DW-1:0] prev_p1;
  logic [AW-1:0] wr_addr_nx, next_addr;
  logic          wr_en_nx, front_sel_nx, full_nx, triggered_nx;
  logic          fire;

  function automatic logic level_cross(input logic [DW-1:0] prv, input logic [DW-1:0] cur,
                                       input logic [DW-1:0] lvl, input logic rise);
    return rise ? ((prv < lvl) && (cur >= lvl)) : ((prv >= lvl) && (cur < lvl));
  endfunction

  assign fire = valid && ((prev_vld && level_cross(prev_p1, sample, trig_level, rising)) ||
                          (auto_en && (tcnt == TMAX)));
  assign next_addr = wr_addr + 1'b1;

  always_comb begin
    state_nx     = state;
    tcnt_nx      = tcnt;
    dcnt_nx      = dcnt;
    decim_lat_nx = decim_lat;
    prev_vld_nx  = prev_vld | valid;
    wr_en_nx     = 1'b0;
    wr_addr_nx   = wr_addr;
    front_sel_nx = front_sel;
    full_nx      = full;
    triggered_nx = 1'b0;
    case (state)
      WAIT_TRIG: begin
        if (fire) begin
          triggered_nx = 1'b1;
          wr_en_nx     = 1'b1;
          wr_addr_nx   = '0;
          decim_lat_nx = decim;
          // The trigger sample already used decimation slot 0.
          dcnt_nx      = (decim == 8'd0) ? 8'd0 : 8'd1;
          tcnt_nx      = '0;
          state_nx     = (NSAMP == 1) ? SWAP_WAIT : CAPTURE;
        end else if (valid && (tcnt != TMAX)) begin
          tcnt_nx = tcnt + 1'b1;
        end
      end
      CAPTURE: begin
        if (valid) begin
          dcnt_nx = (dcnt == decim_lat) ? 8'd0 : dcnt + 8'd1;
          if (dcnt == 8'd0) begin
            wr_en_nx   = 1'b1;
            wr_addr_nx = next_addr;
            if (next_addr == LAST) state_nx = SWAP_WAIT;
          end
        end
      end
      SWAP_WAIT: begin
        // full rises the cycle after the last write; a swap needs full already set,
        // so a frame_start that coincides with the last write is ignored.
        if (!full) begin
          full_nx    = 1'b1;
          wr_addr_nx = '0;
        end else if (frame_start) begin
          front_sel_nx = ~front_sel;
          full_nx      = 1'b0;
          state_nx     = WAIT_TRIG;
        end
      end
      default: state_nx = WAIT_TRIG;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= WAIT_TRIG;
      tcnt      <= '0;
      dcnt      <= '0;
      decim_lat <= '0;
      prev_vld  <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      front_sel <= 1'b0;
      full      <= 1'b0;
      triggered <= 1'b0;
    end else begin
      state     <= state_nx;
      tcnt      <= tcnt_nx;
      dcnt      <= dcnt_nx;
      decim_lat <= decim_lat_nx;
      prev_vld  <= prev_vld_nx;
      wr_en     <= wr_en_nx;
      wr_addr   <= wr_addr_nx;
      front_sel <= front_sel_nx;
      full      <= full_nx;
      triggered <= triggered_nx;
    end
  end

  // Stage p1: the last valid sample is both the trigger history and the write data.
  always_ff @(posedge clk) begin
    if (valid) prev_p1 <= sample;
  end

  assign wr_data = 16'(prev_p1);

endmodule

// File: tb/tb_scope_capture_ctrl.sv
// Bench for scope_capture_ctrl: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural capture model.
`timescale 1ns/1ps
module tb_scope_capture_ctrl;
  localparam int NSAMP = 640, AW = 10, DW = 9, TIMEOUT = 4096;

  logic          clk = 1'b0, reset = 1'b1;
  logic [DW-1:0] sample = '0, trig_level = '0;
  logic          valid = 1'b0, rising = 1'b1, auto_en = 1'b0, frame_start = 1'b0;
  logic [7:0]    decim = '0;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          wr_en, front_sel, full, triggered;

  int n_checks = 0, n_fail = 0;

  scope_capture_ctrl #(.NSAMP(NSAMP), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .sample(sample), .valid(valid), .trig_level(trig_level),
    .rising(rising), .auto_en(auto_en), .decim(decim), .frame_start(frame_start),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .front_sel(front_sel),
    .full(full), .triggered(triggered));

  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Behavioural model: phase 0 searching, 1 capturing, 2 buffer done.
  bit m_ok = 0, have_prev = 0;
  int phase = 0, waited = 0, kept = 0, since = 0, step = 1, prev_s = 0;
  logic e_wr_en = 0, e_trig = 0, e_full = 0, e_front = 0;
  int e_addr = 0, e_data = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_ok = 1; phase = 0; have_prev = 0; waited = 0;
      e_wr_en = 0; e_trig = 0; e_full = 0; e_front = 0; e_addr = 0;
    end else if (m_ok) begin
      int s, lvl;
      bit hit;
      s = int'(sample); lvl = int'(trig_level);
      e_wr_en = 0; e_trig = 0;
      if (phase == 0) begin
        if (valid) begin
          hit = have_prev && (rising ? (prev_s < lvl && s >= lvl) : (prev_s >= lvl && s < lvl));
          if (hit || (auto_en && waited >= TIMEOUT - 1)) begin
            e_trig = 1; e_wr_en = 1; e_addr = 0; e_data = s;
            kept = 1; since = 0; step = int'(decim) + 1; waited = 0;
            phase = (kept == NSAMP) ? 2 : 1;
          end else if (waited < TIMEOUT - 1) begin
            waited++;
          end
        end
      end else if (phase == 1) begin
        if (valid) begin
          since++;
          if (since == step) begin
            since = 0; e_wr_en = 1; e_addr = kept; e_data = s; kept++;
            if (kept == NSAMP) phase = 2;
          end
        end
      end else begin
        if (e_full && frame_start) begin
          e_front = !e_front; e_full = 0; phase = 0;
        end else begin
          e_full = 1;
        end
      end
      if (valid) begin prev_s = s; have_prev = 1; end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("wr_en", wr_en, e_wr_en);
      if (e_wr_en) begin
        chk("wr_addr", wr_addr, e_addr);
        chk("wr_data", wr_data, e_data);
      end
      chk("triggered", triggered, e_trig);
      chk("full", full, e_full);
      chk("front_sel", front_sel, e_front);
    end
  end

  task automatic cyc(input logic v, input logic [DW-1:0] s, input logic fs);
    valid = v; sample = s; frame_start = fs;
    @(posedge clk); #1;
  endtask

  task automatic rst_pulse();
    reset = 1'b1;
    cyc(1'b0, '0, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    #5ms;
    n_fail++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    int trig_data, trig_addr, nwr, last_data, tidx, tdat, ntr, nv, at, prevd, bad;
    bit hit639, rst_done;
    logic [DW-1:0] pat [4];

    // Reset state
    rst_pulse();
    chk("rst_wr_en", wr_en, 0); chk("rst_wr_addr", wr_addr, 0);
    chk("rst_front", front_sel, 0); chk("rst_full", full, 0); chk("rst_trig", triggered, 0);

    // Rising ramp through 256
    trig_level = 9'd256; rising = 1; auto_en = 0; decim = 0;
    trig_data = -1; trig_addr = -1; nwr = 0; last_data = -1;
    for (int i = 0; i < 700; i++) begin
      cyc(1'b1, DW'(250 + i), 1'b0);
      if (triggered && trig_data < 0) begin trig_data = wr_data; trig_addr = wr_addr; end
      if (wr_en) begin nwr++; if (wr_addr == 10'd639) last_data = wr_data; end
    end
    chk("t1_trig_data", trig_data, 256); chk("t1_trig_addr", trig_addr, 0);
    chk("t1_writes", nwr, 640); chk("t1_last_data", last_data, 383);
    chk("t1_full", full, 1); chk("t1_front", front_sel, 0);

    // Swap on frame_start
    cyc(1'b0, '0, 1'b1);
    chk("t5_front", front_sel, 1); chk("t5_full", full, 0);
    cyc(1'b0, '0, 1'b0);

    // Falling edge, then same data with rising
    rst_pulse();
    trig_level = 9'd100; rising = 0;
    pat[0] = 9'd120; pat[1] = 9'd110; pat[2] = 9'd100; pat[3] = 9'd90;
    tidx = -1; tdat = -1;
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, pat[k], 1'b0);
      if (triggered && tidx < 0) begin tidx = k; tdat = wr_data; end
    end
    chk("t2_fall_idx", tidx, 3); chk("t2_fall_data", tdat, 90);
    rst_pulse();
    rising = 1; ntr = 0;
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, pat[k], 1'b0);
      if (triggered) ntr++;
    end
    cyc(1'b0, '0, 1'b0);
    if (triggered) ntr++;
    chk("t2_rise_none", ntr, 0);

    // Auto-trigger on a flat input
    rst_pulse();
    trig_level = 9'd256; rising = 1; auto_en = 1;
    nv = 0; at = -1;
    for (int i = 0; i < 5000; i++) begin
      cyc(1'b1, 9'd50, 1'b0);
      nv++;
      if (triggered) begin at = nv; break; end
    end
    chk("t3_auto_at", at, 4096); chk("t3_auto_data", wr_data, 50);
    rst_pulse();
    auto_en = 0; ntr = 0;
    for (int i = 0; i < 10000; i++) begin
      cyc(1'b1, 9'd50, 1'b0);
      if (triggered) ntr++;
    end
    chk("t3_no_auto", ntr, 0);

    // Decimation by 4, decim changed mid-capture, frame_start on the last write
    rst_pulse();
    decim = 8'd3; nwr = 0; bad = 0; prevd = -1; hit639 = 0;
    for (int i = 0; i < 3000 && !hit639; i++) begin
      cyc(1'b1, DW'(250 + i), 1'b0);
      if (triggered) decim = 8'd0;
      if (wr_en) begin
        nwr++;
        if (prevd >= 0 && ((int'(wr_data) - prevd) & 511) != 4) bad++;
        prevd = wr_data;
        if (wr_addr == 10'd639) hit639 = 1;
      end
    end
    chk("t4_writes", nwr, 640); chk("t4_spacing", bad, 0);
    cyc(1'b0, '0, 1'b1);
    chk("t5_noswap_front", front_sel, 0); chk("t5_noswap_full", full, 1);
    cyc(1'b0, '0, 1'b1);
    chk("t5_late_front", front_sel, 1); chk("t5_late_full", full, 0);

    // Reset in the middle of a capture
    rst_done = 0;
    for (int i = 0; i < 1000 && !rst_done; i++) begin
      cyc(1'b1, DW'(250 + i), 1'b0);
      if (wr_en && wr_addr == 10'd300) rst_done = 1;
    end
    chk("t6_reached_300", rst_done, 1);
    reset = 1'b1;
    cyc(1'b1, 9'd0, 1'b0);
    reset = 1'b0;
    chk("t6_wr_en", wr_en, 0); chk("t6_front", front_sel, 0);
    chk("t6_full", full, 0); chk("t6_trig", triggered, 0);
    trig_addr = -1; trig_data = -1;
    for (int i = 0; i < 40 && trig_addr < 0; i++) begin
      cyc(1'b1, DW'(250 + i), 1'b0);
      if (triggered && wr_en) begin trig_addr = wr_addr; trig_data = wr_data; end
    end
    chk("t6_restart_addr", trig_addr, 0); chk("t6_restart_data", trig_data, 256);

    // Randomized traffic
    rst_pulse();
    ntr = 0;
    for (int c = 0; c < 30000; c++) begin
      if (c % 1500 == 0) begin
        trig_level = DW'($urandom_range(0, 511));
        rising = 1'($urandom_range(0, 1));
        auto_en = 1'($urandom_range(0, 1));
      end
      if (c % 700 == 0) decim = 8'($urandom_range(0, 3));
      reset = (c == 15000) || ($urandom_range(0, 9999) == 0);
      cyc($urandom_range(0, 3) != 0, DW'($urandom_range(0, 511)), $urandom_range(0, 39) == 0);
      if (triggered) ntr++;
    end
    reset = 1'b0;
    cyc(1'b0, '0, 1'b0);
    chk("rand_activity", ntr > 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
